mrd_stage_bfp_ctrl: RTL and testbench
=====================================

// Module: mrd_stage_bfp_ctrl
// PURPOSE
//  Parametrised per-stage control shell for the mixed-radix DFT engine. It wraps an external radix+twiddle datapath and does two jobs.
//  First, it carries the write-back bank/address tags through an internal FIFO so they realign with datapath output samples.
//  Second, it tracks block-floating-point state: it measures the minimum headroom across all lanes of each output burst and accumulates the stage exponent for the next pass.
//  It generalises the fixed 5-lane/18-bit control to NLANE lanes, any WDATA width and any MAX_MARGIN, and adds overflow/underflow status.
// PARAMETERS
//  NLANE      5   complex samples per beat
//  WDATA      18  signed width of each real/imag component
//  WTAG       11  per-lane tag width ({bank_index,bank_addr})
//  DEPTH      32  tag FIFO depth (power of 2)
//  MAX_MARGIN 3   largest reported headroom (guard bits)
//  WEXP       4   accumulated exponent width
// PORTS
//  clk        in  1               clock
//  rst_n      in  1               asynchronous active-low reset
//  sop        in  1               frame start; clears FIFO, margin and exponent
//  tag_valid  in  1               push tags (datapath input beat)
//  tag_in     in  NLANE*WTAG      lane tags, lane0 at LSBs
//  dp_valid   in  1               datapath output beat; pops one FIFO entry
//  dp_real    in  NLANE*WDATA     datapath real outputs
//  dp_imag    in  NLANE*WDATA     datapath imag outputs
//  dp_shift   in  WEXP            right-shift applied by datapath in this burst
//  out_valid  out 1               registered output beat
//  out_tag    out NLANE*WTAG      realigned tags
//  out_real   out NLANE*WDATA     registered dp_real
//  out_imag   out NLANE*WDATA     registered dp_imag
//  margin_nxt out $clog2(MAX_MARGIN+1)  headroom of last complete burst
//  exp_acc    out WEXP            accumulated frame exponent
//  fifo_ovf   out 1               sticky: push while full dropped
//  fifo_udf   out 1               sticky: pop while empty
// BEHAVIOUR
//  Reset:
//   - All outputs and registers are 0; FIFO is empty.
//  Output path:
//   - out_valid/real/imag/tag are registered: 1 cycle after dp_valid.
//   - out_tag comes from the FIFO head popped in the same cycle as dp_valid.
//  FIFO:
//   - Push on tag_valid; pop on dp_valid.
//   - Simultaneous push+pop is legal, including when full or when empty with a same-cycle push.
//   - Same-cycle push+pop on an empty FIFO: the output beat carries the pushed tag (bypass); udf is not set.
//   - Push-only while full: entry dropped; fifo_ovf is set.
//   - Pop while empty, no push: out_tag is 0; fifo_udf is set.
//   - Flags are sticky until sop or reset.
//  Margin:
//   - Per component, m = leading zeros of |x|[WDATA-2:0], clipped to MAX_MARGIN.
//   - The most-negative value gives m=0.
//   - m is computed on out_real/out_imag and registered (+1 cycle).
//   - A combinational min tree over 2*NLANE values feeds run_min.
//  Bursts:
//   - A burst is a maximal run of contiguous out_valid.
//   - run_min loads MAX_MARGIN at the burst's first m-beat, then takes the running min.
//   - margin_nxt <= run_min one cycle after the last m-beat, i.e. 3 cycles after the last dp_valid.
//   - exp_acc += dp_shift, sampled on the rising edge of dp_valid.
//   - exp_acc saturates at 2^WEXP-1.
//  sop:
//   - Sync clear of FIFO, flags, run_min, margin_nxt and exp_acc.
//   - sop overrides any same-cycle burst-end or shift update.
//   - A beat with dp_valid and sop together is still output, but its tag pop reads the cleared FIFO, so out_tag is 0 and fifo_udf is not set.
//  Reset mid-burst:
//   - Outputs drop immediately (async); no partial margin is latched.
// CONFIGURATION
//  MRD_BFP_STATS_EN defined:
//   - Adds outputs stat_bursts[15:0] and stat_beats[23:0].
//   - Both are saturating counters of bursts and out_valid beats, cleared by sop/reset.
//  Undefined:
//   - The ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package mrd_bfp_pkg:
//   - margin_t typedef.
//   - function lead_margin(x, WDATA, MAX_MARGIN).
//   - function sat_add.
//  Sub-module mrd_tag_fifo:
//   - Parametrised sync FIFO with sclr.
//   - Outputs full/empty; push/pop handling as defined above.
//  Top: output register, margin pipeline, burst detect, exponent accumulator.
// TESTING (NLANE=5, WDATA=18, DEPTH=32, MAX_MARGIN=3, WEXP=4)
//  1. Assert rst_n=0 mid-run -> all outputs 0 immediately; FIFO empty after release.
//  2. Push tags T0,T1,T2; then 3 dp_valid beats -> out_tag T0,T1,T2 on out_valid, each 1 cycle after dp_valid.
//  3. Four-beat burst, max |x|=0x03000, others smaller -> margin_nxt=3. Repeat with one sample -131072 -> margin_nxt=0.
//  4. Bursts with dp_shift=2,2,2 -> exp_acc 2,4,6. Then dp_shift=15 -> exp_acc=15 (saturated).
//  5. Push 33 beats with no pop -> fifo_ovf=1 and the 33rd tag is lost. Pop 33 -> fifo_udf=1, last out_tag=0.
//  6. sop coincident with a burst end and dp_shift=3 -> margin_nxt=0, exp_acc=0, flags cleared.

Source files
------------

// File: rtl/mrd_bfp_pkg.sv
// Shared types and helpers for the mixed-radix stage block-floating-point control.
package mrd_bfp_pkg;

  typedef logic [7:0] margin_t;

  // Guard bits of a sign-extended sample: leading zeros of |x| below the sign
  // position, clipped. The most-negative value has no headroom at all.
  function automatic margin_t lead_margin(input logic signed [63:0] x,
                                          input int wdata, input int max_margin);
    logic [63:0] a;
    margin_t     m;
    logic        done;
    a    = x[63] ? -x : x;
    m    = '0;
    done = a[wdata-1];
    for (int i = 62; i >= 0; i--) begin
      if (!done && i <= wdata - 2) begin
        if (a[i]) done = 1'b1;
        else if (int'(m) < max_margin) m = m + 8'd1;
      end
    end
    return m;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/mrd_tag_fifo.sv
// Sync tag FIFO with synchronous clear; empty push+pop bypasses din to dout.
module mrd_tag_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_wr, do_rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  // A pop frees the slot for a same-cycle push; empty push+pop never lands in memory.
  assign do_wr = push && !sclr && (!full || pop) && !(empty && pop);
  assign do_rd = pop && !sclr && !empty;

  always_comb begin
    dout = '0;
    if (!sclr) begin
      if (!empty)    dout = mem[rd_ptr];
      else if (push) dout = din;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mrd_stage_bfp_ctrl.sv
// Per-stage control shell: tag realignment FIFO plus block-floating-point margin/exponent tracking.
// Define MRD_BFP_STATS_EN to add saturating burst/beat counters.
module mrd_stage_bfp_ctrl
  import mrd_bfp_pkg::*;
#(
  parameter int NLANE      = 5,
  parameter int WDATA      = 18,
  parameter int WTAG       = 11,
  parameter int DEPTH      = 32,
  parameter int MAX_MARGIN = 3,
  parameter int WEXP       = 4,
  localparam int MW        = (MAX_MARGIN > 0) ? $clog2(MAX_MARGIN + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sop,
  input  logic                   tag_valid,
  input  logic [NLANE*WTAG-1:0]  tag_in,
  input  logic                   dp_valid,
  input  logic [NLANE*WDATA-1:0] dp_real,
  input  logic [NLANE*WDATA-1:0] dp_imag,
  input  logic [WEXP-1:0]        dp_shift,
  output logic                   out_valid,
  output logic [NLANE*WTAG-1:0]  out_tag,
  output logic [NLANE*WDATA-1:0] out_real,
  output logic [NLANE*WDATA-1:0] out_imag,
  output logic [MW-1:0]          margin_nxt,
  output logic [WEXP-1:0]        exp_acc,
  output logic                   fifo_ovf,
  output logic                   fifo_udf
`ifdef MRD_BFP_STATS_EN
  ,
  output logic [15:0]            stat_bursts,
  output logic [23:0]            stat_beats
`endif
);
  localparam int NC = 2 * NLANE;

  logic [NLANE*WTAG-1:0] fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic [NC-1:0][MW-1:0] m_reg;
  logic [MW-1:0]         min_m, run_min;
  logic                  m_vld, m_vld_d;

  mrd_tag_fifo #(.WIDTH(NLANE*WTAG), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sop),
    .push  (tag_valid),
    .din   (tag_in),
    .pop   (dp_valid),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      out_valid <= dp_valid;
      if (dp_valid) begin
        out_tag  <= fifo_dout;
        out_real <= dp_real;
        out_imag <= dp_imag;
      end
    end
  end

  // Per-component headroom of the registered beat; even slots real, odd imag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= '0;
    end else if (out_valid) begin
      for (int l = 0; l < NLANE; l++) begin
        m_reg[2*l]   <= MW'(lead_margin(64'($signed(out_real[l*WDATA +: WDATA])), WDATA, MAX_MARGIN));
        m_reg[2*l+1] <= MW'(lead_margin(64'($signed(out_imag[l*WDATA +: WDATA])), WDATA, MAX_MARGIN));
      end
    end
  end

  always_comb begin
    min_m = MW'(MAX_MARGIN);
    for (int i = 0; i < NC; i++)
      if (m_reg[i] < min_m) min_m = m_reg[i];
  end

  // out_valid doubles as the previous dp_valid, so dp_valid && !out_valid is the burst start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld      <= 1'b0;
      m_vld_d    <= 1'b0;
      run_min    <= '0;
      margin_nxt <= '0;
      exp_acc    <= '0;
      fifo_ovf   <= 1'b0;
      fifo_udf   <= 1'b0;
    end else begin
      m_vld   <= out_valid;
      m_vld_d <= m_vld;
      if (sop) begin
        run_min    <= '0;
        margin_nxt <= '0;
        exp_acc    <= '0;
        fifo_ovf   <= 1'b0;
        fifo_udf   <= 1'b0;
      end else begin
        if (m_vld && !m_vld_d)            run_min <= min_m;
        else if (m_vld && min_m < run_min) run_min <= min_m;
        if (m_vld_d && !m_vld) margin_nxt <= run_min;
        if (dp_valid && !out_valid)
          exp_acc <= WEXP'(sat_add(32'(exp_acc), 32'(dp_shift), WEXP));
        if (tag_valid && !dp_valid && fifo_full)  fifo_ovf <= 1'b1;
        if (dp_valid && !tag_valid && fifo_empty) fifo_udf <= 1'b1;
      end
    end
  end

`ifdef MRD_BFP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts <= '0;
      stat_beats  <= '0;
    end else if (sop) begin
      stat_bursts <= '0;
      stat_beats  <= '0;
    end else if (out_valid) begin
      if (!m_vld) stat_bursts <= 16'(sat_add(32'(stat_bursts), 32'd1, 16));
      stat_beats <= 24'(sat_add(32'(stat_beats), 32'd1, 24));
    end
  end
`endif

endmodule

// File: tb/tb_mrd_stage_bfp_ctrl.sv
// Randomised self-checking bench for mrd_stage_bfp_ctrl against a queue/arithmetic reference model.
module tb_mrd_stage_bfp_ctrl;
  localparam int NLANE = 5, WDATA = 18, WTAG = 11, DEPTH = 32, MAXM = 3, WEXP = 4;
  localparam int TW = NLANE * WTAG;
  localparam int DW = NLANE * WDATA;

  logic          clk, rst_n, sop, tag_valid, dp_valid;
  logic [TW-1:0] tag_in, out_tag;
  logic [DW-1:0] dp_real, dp_imag, out_real, out_imag;
  logic [WEXP-1:0] dp_shift, exp_acc;
  logic [1:0]    margin_nxt;
  logic          out_valid, fifo_ovf, fifo_udf;
`ifdef MRD_BFP_STATS_EN
  logic [15:0]   stat_bursts;
  logic [23:0]   stat_beats;
`endif

  mrd_stage_bfp_ctrl #(.NLANE(NLANE), .WDATA(WDATA), .WTAG(WTAG), .DEPTH(DEPTH),
                       .MAX_MARGIN(MAXM), .WEXP(WEXP)) dut (
    .clk(clk), .rst_n(rst_n), .sop(sop), .tag_valid(tag_valid), .tag_in(tag_in),
    .dp_valid(dp_valid), .dp_real(dp_real), .dp_imag(dp_imag), .dp_shift(dp_shift),
    .out_valid(out_valid), .out_tag(out_tag), .out_real(out_real), .out_imag(out_imag),
    .margin_nxt(margin_nxt), .exp_acc(exp_acc), .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf)
`ifdef MRD_BFP_STATS_EN
    , .stat_bursts(stat_bursts), .stat_beats(stat_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int re[NLANE], im[NLANE];
  int mdl_margin = 0, mdl_exp = 0;
  logic [TW-1:0] q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tag_valid = 1'b0; dp_valid = 1'b0; sop = 1'b0; dp_shift = '0;
  endtask

  task automatic pack();
    for (int l = 0; l < NLANE; l++) begin
      dp_real[l*WDATA +: WDATA] = WDATA'(re[l]);
      dp_imag[l*WDATA +: WDATA] = WDATA'(im[l]);
    end
  endtask

  function automatic logic [TW-1:0] rand_tag();
    return TW'({$urandom(), $urandom()});
  endfunction

  function automatic int rand_sample(input int maxbits);
    int b, v;
    b = int'($urandom_range(0, maxbits));
    v = (b == 0) ? 0 : int'($urandom_range(0, (1 << b) - 1));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  // Headroom = (WDATA-1) minus the bit length of |v|, clipped to [0, MAXM].
  function automatic int ref_margin(input int v);
    int a, bl, m;
    a = (v < 0) ? -v : v;
    if (a >= (1 << (WDATA - 1))) return 0;
    bl = 0;
    while (a > 0) begin a = a / 2; bl++; end
    m = (WDATA - 1) - bl;
    return (m > MAXM) ? MAXM : m;
  endfunction

  task automatic do_sop();
    idle();
    repeat (4) step();
    sop = 1'b1;
    step();
    sop = 1'b0;
    mdl_margin = 0; mdl_exp = 0;
    q.delete();
  endtask

  // mode 0: random, 1: one |x|=0x3000 among small values, 2: one -131072 among random
  task automatic run_burst(input int nb, input int shift, input int mode);
    int exp_m, fb, fl, fc;
    logic [DW-1:0] er;
    exp_m = MAXM;
    fb = int'($urandom_range(0, nb - 1));
    fl = int'($urandom_range(0, NLANE - 1));
    fc = int'($urandom_range(0, 1));
    for (int k = 0; k < nb; k++) begin
      for (int l = 0; l < NLANE; l++) begin
        re[l] = (mode == 1) ? rand_sample(11) : rand_sample(17);
        im[l] = (mode == 1) ? rand_sample(11) : rand_sample(17);
      end
      if (k == fb && mode == 1) begin if (fc == 0) re[fl] = 'h3000; else im[fl] = -'h3000; end
      if (k == fb && mode == 2) begin if (fc == 0) re[fl] = -131072; else im[fl] = -131072; end
      for (int l = 0; l < NLANE; l++) begin
        if (ref_margin(re[l]) < exp_m) exp_m = ref_margin(re[l]);
        if (ref_margin(im[l]) < exp_m) exp_m = ref_margin(im[l]);
      end
      pack();
      er = dp_real;
      dp_valid = 1'b1;
      dp_shift = (k == 0) ? WEXP'(shift) : WEXP'($urandom_range(0, 15));
      step();
      if (k == 0) mdl_exp = (mdl_exp + shift > 15) ? 15 : mdl_exp + shift;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL burst_valid: got %0b expected 1", out_valid); end
      checks++; if (out_real !== er) begin errors++; $display("FAIL burst_real: got %0h expected %0h", out_real, er); end
      checks++; if (exp_acc !== WEXP'(mdl_exp)) begin errors++; $display("FAIL exp_acc: got %0d expected %0d", exp_acc, mdl_exp); end
    end
    dp_valid = 1'b0; dp_shift = '0;
    step(); step();
    checks++; if (margin_nxt !== 2'(mdl_margin)) begin errors++; $display("FAIL margin_early: got %0d expected %0d", margin_nxt, mdl_margin); end
    step();
    mdl_margin = exp_m;
    checks++; if (margin_nxt !== 2'(mdl_margin)) begin errors++; $display("FAIL margin_nxt: got %0d expected %0d", margin_nxt, mdl_margin); end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); tag_in = '0;
    for (int l = 0; l < NLANE; l++) begin re[l] = 0; im[l] = 0; end
    pack();
    step(); step();
    checks++; if ({out_valid, out_tag, out_real, out_imag, margin_nxt, exp_acc, fifo_ovf, fifo_udf} !== '0)
      begin errors++; $display("FAIL reset_state: outputs not all zero"); end
    rst_n = 1'b1;
    step();
    for (int l = 0; l < NLANE; l++) begin re[l] = rand_sample(17); im[l] = rand_sample(17); end
    pack();
    tag_valid = 1'b1; tag_in = rand_tag(); dp_valid = 1'b1; dp_shift = 4'd5;
    step();
    checks++; if (exp_acc !== 4'd5) begin errors++; $display("FAIL pre_reset_exp: got %0d expected 5", exp_acc); end
    dp_valid = 1'b0; tag_in = rand_tag();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_tag, out_real, out_imag, margin_nxt, exp_acc, fifo_ovf, fifo_udf} !== '0)
      begin errors++; $display("FAIL async_reset: outputs not zero, valid=%0b exp=%0d", out_valid, exp_acc); end
    idle(); mdl_exp = 0; mdl_margin = 0;
    step();
    rst_n = 1'b1;
    step();
    dp_valid = 1'b1;
    step();
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_fifo_empty: got %0h expected 0", out_tag); end
    checks++; if (fifo_udf !== 1'b1) begin errors++; $display("FAIL reset_udf: got %0b expected 1", fifo_udf); end
    dp_valid = 1'b0;
    step();
  endtask

  task automatic test_tags();
    logic [TW-1:0] t[3];
    do_sop();
    for (int k = 0; k < 3; k++) begin
      tag_valid = 1'b1; t[k] = rand_tag(); tag_in = t[k];
      step();
    end
    tag_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dp_valid = 1'b1;
      checks++; if (out_tag === t[k] && k > 0) begin errors++; $display("FAIL tag_early: tag %0d visible before its beat", k); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tag_valid: got %0b expected 1", out_valid); end
      checks++; if (out_tag !== t[k]) begin errors++; $display("FAIL tag_order: got %0h expected %0h", out_tag, t[k]); end
    end
    dp_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tag_valid_drop: got %0b expected 0", out_valid); end
    checks++; if (fifo_udf !== 1'b0) begin errors++; $display("FAIL tag_udf: got %0b expected 0", fifo_udf); end
  endtask

  task automatic test_margin();
    do_sop();
    run_burst(4, 0, 1);
    checks++; if (margin_nxt !== 2'd3) begin errors++; $display("FAIL margin_0x3000: got %0d expected 3", margin_nxt); end
    run_burst(4, 0, 2);
    checks++; if (margin_nxt !== 2'd0) begin errors++; $display("FAIL margin_mostneg: got %0d expected 0", margin_nxt); end
    for (int i = 0; i < 6; i++) run_burst(int'($urandom_range(1, 6)), 0, 0);
  endtask

  task automatic test_exp();
    do_sop();
    run_burst(2, 2, 0);
    checks++; if (exp_acc !== 4'd2) begin errors++; $display("FAIL exp_2: got %0d expected 2", exp_acc); end
    run_burst(3, 2, 0);
    checks++; if (exp_acc !== 4'd4) begin errors++; $display("FAIL exp_4: got %0d expected 4", exp_acc); end
    run_burst(1, 2, 0);
    checks++; if (exp_acc !== 4'd6) begin errors++; $display("FAIL exp_6: got %0d expected 6", exp_acc); end
    run_burst(2, 15, 0);
    checks++; if (exp_acc !== 4'd15) begin errors++; $display("FAIL exp_sat: got %0d expected 15", exp_acc); end
  endtask

  task automatic test_fifo_flags();
    logic [TW-1:0] tv, et;
    do_sop();
    checks++; if ({fifo_ovf, fifo_udf} !== 2'b00) begin errors++; $display("FAIL flags_clear: got %0b%0b expected 00", fifo_ovf, fifo_udf); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      tv = rand_tag(); tag_valid = 1'b1; tag_in = tv;
      if (q.size() < DEPTH) q.push_back(tv);
      step();
      if (k == DEPTH - 1) begin
        checks++; if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %0b expected 0", fifo_ovf); end
      end
    end
    tag_valid = 1'b0;
    checks++; if (fifo_ovf !== 1'b1) begin errors++; $display("FAIL ovf: got %0b expected 1", fifo_ovf); end
    checks++; if (fifo_udf !== 1'b0) begin errors++; $display("FAIL udf_early: got %0b expected 0", fifo_udf); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      dp_valid = 1'b1;
      et = (q.size() > 0) ? q.pop_front() : '0;
      step();
      checks++; if (out_tag !== et) begin errors++; $display("FAIL drain_tag%0d: got %0h expected %0h", k, out_tag, et); end
    end
    dp_valid = 1'b0;
    checks++; if (fifo_udf !== 1'b1) begin errors++; $display("FAIL udf: got %0b expected 1", fifo_udf); end
    step();
  endtask

  task automatic test_sop();
    int exp_m;
    idle();
    for (int k = 0; k < 3; k++) begin tag_valid = 1'b1; tag_in = rand_tag(); step(); end
    tag_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < NLANE; l++) begin re[l] = rand_sample(8); im[l] = rand_sample(8); end
      pack(); dp_valid = 1'b1; dp_shift = 4'd1;
      step();
    end
    dp_valid = 1'b0;
    step(); step();
    exp_m = MAXM;
    for (int l = 0; l < NLANE; l++) begin
      re[l] = rand_sample(17); im[l] = rand_sample(17);
      if (ref_margin(re[l]) < exp_m) exp_m = ref_margin(re[l]);
      if (ref_margin(im[l]) < exp_m) exp_m = ref_margin(im[l]);
    end
    pack();
    sop = 1'b1; dp_valid = 1'b1; dp_shift = 4'd3;
    step();
    sop = 1'b0; dp_valid = 1'b0; dp_shift = '0;
    checks++; if (margin_nxt !== 2'd0) begin errors++; $display("FAIL sop_margin: got %0d expected 0", margin_nxt); end
    checks++; if (exp_acc !== 4'd0) begin errors++; $display("FAIL sop_exp: got %0d expected 0", exp_acc); end
    checks++; if ({fifo_ovf, fifo_udf} !== 2'b00) begin errors++; $display("FAIL sop_flags: got %0b%0b expected 00", fifo_ovf, fifo_udf); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sop_beat_valid: got %0b expected 1", out_valid); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL sop_beat_tag: got %0h expected 0", out_tag); end
    step(); step(); step();
    checks++; if (margin_nxt !== 2'(exp_m)) begin errors++; $display("FAIL sop_next_margin: got %0d expected %0d", margin_nxt, exp_m); end
    checks++; if (exp_acc !== 4'd0) begin errors++; $display("FAIL sop_exp_hold: got %0d expected 0", exp_acc); end
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL sop_fifo_cleared: got %0h expected 0", out_tag); end
    checks++; if (fifo_udf !== 1'b1) begin errors++; $display("FAIL sop_post_udf: got %0b expected 1", fifo_udf); end
    step();
  endtask

  task automatic test_random();
    int ppush, ppop;
    logic m_ovf, m_udf, consumed, pu, po;
    logic [TW-1:0] tv, et;
    do_sop();
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      ppush = (c < 120) ? 80 : (c < 240) ? 25 : 50;
      ppop  = (c < 120) ? 25 : (c < 240) ? 80 : 50;
      pu = ($urandom_range(0, 99) < ppush);
      po = ($urandom_range(0, 99) < ppop);
      tv = rand_tag();
      tag_valid = pu; tag_in = tv; dp_valid = po;
      for (int l = 0; l < NLANE; l++) begin re[l] = rand_sample(17); im[l] = rand_sample(17); end
      pack();
      et = '0; consumed = 1'b0;
      if (po) begin
        if (q.size() > 0) et = q.pop_front();
        else if (pu) begin et = tv; consumed = 1'b1; end
        else m_udf = 1'b1;
      end
      if (pu && !consumed) begin
        if (q.size() < DEPTH) q.push_back(tv);
        else m_ovf = 1'b1;
      end
      step();
      checks++; if (out_valid !== po) begin errors++; $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, out_valid, po); end
      if (po) begin
        checks++; if (out_tag !== et) begin errors++; $display("FAIL rnd_tag c%0d: got %0h expected %0h", c, out_tag, et); end
      end
      checks++; if ({fifo_ovf, fifo_udf} !== {m_ovf, m_udf})
        begin errors++; $display("FAIL rnd_flags c%0d: got %0b%0b expected %0b%0b", c, fifo_ovf, fifo_udf, m_ovf, m_udf); end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_tags();
    test_margin();
    test_exp();
    test_fifo_flags();
    test_sop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
